// File: rtl/vector_checker.sv
// Stored-vector test sequencer: replays input vectors into a DUT, compares
// masked responses against expected values and records mismatch statistics.
module vector_checker #(
  parameter int unsigned NI     = 3,
  parameter int unsigned NO     = 1,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned AW     = 10,
  parameter int unsigned SETTLE = 1,
  parameter int unsigned CW     = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                ld_en,
  input  logic [AW-1:0]       ld_addr,
  input  logic [NI+2*NO-1:0]  ld_data,
  input  logic [AW:0]         num_vec,
  input  logic                start,
  input  logic                halt_on_err,
  output logic [NI-1:0]       dut_in,
  input  logic [NO-1:0]       dut_out,
  output logic                busy,
  output logic                done,
  output logic [AW:0]         vec_idx,
  output logic [CW-1:0]       err_cnt,
  output logic                err_pulse,
  output logic [AW-1:0]       err_idx,
  output logic [NO-1:0]       err_got,
  output logic [NO-1:0]       err_exp
);

  localparam int unsigned W       = NI + 2 * NO;
  localparam int unsigned SW      = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam int unsigned MAW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_N = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, FETCH, APPLY, WAIT, CHECK, DONE} state_t;

  state_t          state;
  logic [W-1:0]    mem [DEPTH];
  logic [W-1:0]    rd_word;
  logic [AW:0]     num_lat;
  logic            halt_lat;
  logic [SW-1:0]   settle_cnt;

  logic            idle_c;
  logic [NI-1:0]   vin_c;
  logic [NO-1:0]   vexp_c;
  logic [NO-1:0]   vmask_c;
  logic            miss_c;
  logic [AW:0]     nv_c;
  logic [AW:0]     next_idx_c;

  // Field split of the fetched word and mismatch detection
  always_comb begin
    idle_c     = (state == IDLE) || (state == DONE);
    vin_c      = rd_word[W-1:2*NO];
    vexp_c     = rd_word[2*NO-1:NO];
    vmask_c    = rd_word[NO-1:0];
    miss_c     = |((dut_out ^ vexp_c) & vmask_c);
    nv_c       = (num_vec > DEPTH_N) ? DEPTH_N : num_vec;
    next_idx_c = vec_idx + 1'b1;
  end

  // Vector memory: no reset, writes only while not running, registered read
  always_ff @(posedge clk) begin
    if (reset_n && idle_c && ld_en && (32'(ld_addr) < DEPTH)) begin
      mem[MAW'(ld_addr)] <= ld_data;
    end
    if (state == FETCH) begin
      rd_word <= mem[MAW'(vec_idx)];
    end
  end

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      dut_in     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      vec_idx    <= '0;
      err_cnt    <= '0;
      err_pulse  <= 1'b0;
      err_idx    <= '0;
      err_got    <= '0;
      err_exp    <= '0;
      num_lat    <= '0;
      halt_lat   <= 1'b0;
      settle_cnt <= '0;
    end else begin
      err_pulse <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            vec_idx  <= '0;
            err_cnt  <= '0;
            err_idx  <= '0;
            err_got  <= '0;
            err_exp  <= '0;
            num_lat  <= nv_c;
            halt_lat <= halt_on_err;
            if (nv_c == '0) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state <= FETCH;
              done  <= 1'b0;
              busy  <= 1'b1;
            end
          end
        end
        FETCH: state <= APPLY;
        APPLY: begin
          dut_in     <= vin_c;
          settle_cnt <= SW'(SETTLE);
          state      <= (SETTLE > 0) ? WAIT : CHECK;
        end
        WAIT: begin
          if (settle_cnt <= SW'(1)) begin
            state <= CHECK;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        CHECK: begin
          vec_idx <= next_idx_c;
          if (miss_c) begin
            err_pulse <= 1'b1;
            if (err_cnt != '1) begin
              err_cnt <= err_cnt + 1'b1;
            end
            // err_cnt never wraps, so zero means no earlier mismatch this run
            if (err_cnt == '0) begin
              err_idx <= AW'(vec_idx);
              err_got <= dut_out;
              err_exp <= vexp_c;
            end
          end
          if ((next_idx_c == num_lat) || (miss_c && halt_lat)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_checker.sv
// Bench for vector_checker: three builds (SETTLE 1/0/5) share one stimulus
// stream and are compared each cycle against a timeline model of the run.
module tb_vector_checker;

  localparam int unsigned AW = 10;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            ld_en;
  logic [AW-1:0]   ld_addr;
  logic [4:0]      ld_data;
  logic [AW:0]     num_vec;
  logic            start;
  logic            halt_on_err;

  logic [2:0]  din0, din1, din2;
  logic        dout0, dout1, dout2;
  logic        busy0, busy1, busy2, done0, done1, done2;
  logic        pulse0, pulse1, pulse2;
  logic [AW:0] vidx0, vidx1, vidx2;
  logic [31:0] cnt0;
  logic [1:0]  cnt1, cnt2;
  logic [AW-1:0] eidx0, eidx1, eidx2;
  logic        got0, got1, got2, exp0, exp1, exp2;

  always #5 clk = ~clk;

  function automatic logic fy(input logic [2:0] v);
    logic a, b, c;
    a = v[2]; b = v[1]; c = v[0];
    return (~a & ~b & ~c) | (a & ~b & ~c) | (a & ~b & c);
  endfunction

  assign dout0 = fy(din0);
  assign dout1 = fy(din1);
  assign dout2 = fy(din2);

  vector_checker #(.SETTLE(1)) u0 (
    .clk(clk), .reset_n(reset_n), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .num_vec(num_vec), .start(start), .halt_on_err(halt_on_err), .dut_in(din0),
    .dut_out(dout0), .busy(busy0), .done(done0), .vec_idx(vidx0), .err_cnt(cnt0),
    .err_pulse(pulse0), .err_idx(eidx0), .err_got(got0), .err_exp(exp0));

  vector_checker #(.SETTLE(0), .CW(2)) u1 (
    .clk(clk), .reset_n(reset_n), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .num_vec(num_vec), .start(start), .halt_on_err(halt_on_err), .dut_in(din1),
    .dut_out(dout1), .busy(busy1), .done(done1), .vec_idx(vidx1), .err_cnt(cnt1),
    .err_pulse(pulse1), .err_idx(eidx1), .err_got(got1), .err_exp(exp1));

  vector_checker #(.SETTLE(5), .CW(2)) u2 (
    .clk(clk), .reset_n(reset_n), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .num_vec(num_vec), .start(start), .halt_on_err(halt_on_err), .dut_in(din2),
    .dut_out(dout2), .busy(busy2), .done(done2), .vec_idx(vidx2), .err_cnt(cnt2),
    .err_pulse(pulse2), .err_idx(eidx2), .err_got(got2), .err_exp(exp2));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int i, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s[u%0d] got=%0d expected=%0d at %0t", nm, i, got, want, $time);
    end
  endtask

  // Model state: memory image and the run snapshot taken at the start edge
  logic [4:0] shadow [16];
  logic [2:0] vin [16];
  logic       vexp [16];
  bit         mism [16];
  int         nvec, nrun, ecnt;
  bit         mode, chk_on;
  int         done_at [3];
  int         pulses [3];
  int         settle_of [3] = '{1, 0, 5};
  longint     cmax [3] = '{64'hFFFF_FFFF, 3, 3};

  // Sampled DUT outputs of one instance
  logic        s_busy, s_done, s_pulse, s_got, s_exp;
  logic [AW:0] s_vidx;
  logic [31:0] s_cnt;
  logic [AW-1:0] s_eidx;
  logic [2:0]  s_din;

  task automatic sample(input int i);
    case (i)
      0: begin s_busy = busy0; s_done = done0; s_pulse = pulse0; s_vidx = vidx0; s_cnt = cnt0;
               s_eidx = eidx0; s_got = got0; s_exp = exp0; s_din = din0; end
      1: begin s_busy = busy1; s_done = done1; s_pulse = pulse1; s_vidx = vidx1; s_cnt = 32'(cnt1);
               s_eidx = eidx1; s_got = got1; s_exp = exp1; s_din = din1; end
      default: begin s_busy = busy2; s_done = done2; s_pulse = pulse2; s_vidx = vidx2; s_cnt = 32'(cnt2);
               s_eidx = eidx2; s_got = got2; s_exp = exp2; s_din = din2; end
    endcase
  endtask

  // Per-cycle comparison against the run timeline: vector k occupies
  // P = SETTLE+3 cycles, its check result lands on edge (k+1)*P after start.
  int     p, fin, ve, fi;
  longint cnt;
  logic   w_busy, w_done, w_pulse, w_got, w_exp, din_chk;
  logic [AW:0] w_vidx;
  logic [AW-1:0] w_eidx;
  logic [2:0] w_din;

  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 3; i++) begin
        sample(i);
        if (!mode) begin
          w_busy = 0; w_done = 0; w_pulse = 0; w_vidx = '0; cnt = 0;
          w_eidx = '0; w_got = 0; w_exp = 0; din_chk = 1; w_din = '0;
        end else begin
          p   = settle_of[i] + 3;
          fin = nrun * p;
          ve  = ecnt / p;
          if (ve > nrun) ve = nrun;
          cnt = 0; fi = -1;
          for (int k = 0; k < ve; k++) begin
            if (mism[k]) begin
              cnt++;
              if (fi < 0) fi = k;
            end
          end
          if (cnt > cmax[i]) cnt = cmax[i];
          w_done  = (ecnt >= fin);
          w_busy  = !w_done;
          w_vidx  = (AW + 1)'(ve);
          w_pulse = 0;
          if (ecnt >= p && (ecnt % p) == 0 && (ecnt / p) <= nrun) w_pulse = mism[ecnt / p - 1];
          w_eidx  = (fi >= 0) ? AW'(fi) : '0;
          w_got   = (fi >= 0) ? fy(vin[fi]) : 1'b0;
          w_exp   = (fi >= 0) ? vexp[fi] : 1'b0;
          din_chk = 0; w_din = '0;
          if (w_done && nrun > 0) begin
            din_chk = 1; w_din = vin[nrun - 1];
          end else if (!w_done && (ecnt % p) == p - 1) begin
            din_chk = 1; w_din = vin[ecnt / p];
          end
          if (s_done === 1'b1 && done_at[i] < 0) done_at[i] = ecnt;
          if (s_pulse === 1'b1) pulses[i]++;
        end
        chk("busy", i, 64'(s_busy), 64'(w_busy));
        chk("done", i, 64'(s_done), 64'(w_done));
        chk("vec_idx", i, 64'(s_vidx), 64'(w_vidx));
        chk("err_cnt", i, 64'(s_cnt), 64'(cnt));
        chk("err_pulse", i, 64'(s_pulse), 64'(w_pulse));
        chk("err_idx", i, 64'(s_eidx), 64'(w_eidx));
        chk("err_got", i, 64'(s_got), 64'(w_got));
        chk("err_exp", i, 64'(s_exp), 64'(w_exp));
        if (din_chk) chk("dut_in", i, 64'(s_din), 64'(w_din));
      end
      if (mode) ecnt++;
    end
  end

  task automatic snap(input int n, input bit h);
    nvec = (n > 1024) ? 1024 : n;
    nrun = 0;
    for (int k = 0; k < nvec && k < 16; k++) begin
      vin[k]  = shadow[k][4:2];
      vexp[k] = shadow[k][1];
      mism[k] = ((fy(vin[k]) ^ vexp[k]) & shadow[k][0]) != 1'b0;
    end
    for (int k = 0; k < nvec; k++) begin
      nrun = k + 1;
      if (h && mism[k]) break;
    end
    for (int i = 0; i < 3; i++) begin
      done_at[i] = -1;
      pulses[i]  = 0;
    end
    ecnt = 0;
    mode = 1;
  endtask

  // All drivers are called just after a rising edge
  task automatic wr(input int a, input logic [4:0] d);
    ld_en = 1; ld_addr = AW'(a); ld_data = d;
    shadow[a] = d;
    @(posedge clk); #1;
    ld_en = 0;
  endtask

  task automatic run(input int n, input bit h);
    start = 1; num_vec = (AW + 1)'(n); halt_on_err = h;
    @(posedge clk);
    snap(n, h);
    #1 start = 0;
  endtask

  task automatic wr_run(input int a, input logic [4:0] d, input int n);
    ld_en = 1; ld_addr = AW'(a); ld_data = d; shadow[a] = d;
    start = 1; num_vec = (AW + 1)'(n); halt_on_err = 0;
    @(posedge clk);
    snap(n, 0);
    #1 start = 0; ld_en = 0;
  endtask

  task automatic wait_done();
    int c = 0;
    while (!(done0 && done1 && done2) && c < 2000) begin
      @(posedge clk); #1;
      c++;
    end
    if (!(done0 && done1 && done2)) chk("done_timeout", 0, 64'(c), 64'(0));
    @(negedge clk); #1;
  endtask

  function automatic logic [4:0] word(input int k, input bit flip);
    logic [2:0] v;
    v = 3'(k);
    return {v, fy(v) ^ flip, 1'b1};
  endfunction

  initial begin
    reset_n = 0; ld_en = 0; ld_addr = '0; ld_data = '0;
    num_vec = '0; start = 0; halt_on_err = 0;
    mode = 0; chk_on = 0; ecnt = 0; nrun = 0;
    for (int i = 0; i < 3; i++) begin done_at[i] = -1; pulses[i] = 0; end
    repeat (3) @(posedge clk);
    #1 reset_n = 1; chk_on = 1;
    @(negedge clk); #1;
    chk("rst_vec_idx", 0, 64'(vidx0), 0);

    // Clean run and per-vector timing of each build
    for (int k = 0; k < 8; k++) wr(k, word(k, 0));
    run(8, 0); wait_done();
    chk("clean_done_at", 0, 64'(done_at[0]), 32);
    chk("clean_done_at", 1, 64'(done_at[1]), 24);
    chk("clean_done_at", 2, 64'(done_at[2]), 64);
    chk("clean_cnt", 0, 64'(cnt0), 0);
    chk("clean_vidx", 0, 64'(vidx0), 8);
    chk("clean_pulses", 0, 64'(pulses[0]), 0);

    // Corrupted vectors 3 and 6
    wr(3, word(3, 1)); wr(6, word(6, 1));
    run(8, 0); wait_done();
    chk("corr_cnt", 0, 64'(cnt0), 2);
    chk("corr_pulses", 0, 64'(pulses[0]), 2);
    chk("corr_idx", 0, 64'(eidx0), 3);
    chk("corr_got", 0, 64'(got0), 0);
    chk("corr_exp", 0, 64'(exp0), 1);
    chk("corr_vidx", 0, 64'(vidx0), 8);

    // Halt on first error
    run(8, 1); wait_done();
    chk("halt_vidx", 0, 64'(vidx0), 4);
    chk("halt_cnt", 0, 64'(cnt0), 1);
    chk("halt_idx", 0, 64'(eidx0), 3);

    // Masked mismatch, written in the same cycle as start
    wr_run(0, {3'd3, 1'b1, 1'b0}, 1); wait_done();
    chk("mask_cnt", 0, 64'(cnt0), 0);
    chk("mask_vidx", 0, 64'(vidx0), 1);

    // Zero-length run
    run(0, 0); wait_done();
    chk("zero_done_at", 0, 64'(done_at[0]), 0);
    chk("zero_vidx", 0, 64'(vidx0), 0);

    // start and ld_en while busy have no effect
    for (int k = 0; k < 8; k++) wr(k, word(k, 0));
    run(8, 0);
    @(posedge clk); @(posedge clk); #1;
    start = 1; num_vec = 2; ld_en = 1; ld_addr = 5; ld_data = word(5, 1);
    @(posedge clk); #1;
    start = 0; ld_en = 0;
    wait_done();
    chk("busy_req_vidx", 0, 64'(vidx0), 8);
    chk("busy_req_cnt", 0, 64'(cnt0), 0);
    chk("busy_req_done_at", 0, 64'(done_at[0]), 32);

    // Reset while u0 is in WAIT of vector 2
    run(8, 0);
    repeat (10) @(posedge clk);
    #1 reset_n = 0;
    @(posedge clk);
    mode = 0;
    #1 reset_n = 1;
    @(negedge clk); #1;
    chk("rst_busy", 0, 64'(busy0), 0);
    chk("rst_done", 0, 64'(done0), 0);
    chk("rst_din", 0, 64'(din0), 0);
    run(8, 0); wait_done();
    chk("post_rst_cnt", 0, 64'(cnt0), 0);
    chk("post_rst_vidx", 0, 64'(vidx0), 8);

    // Counter saturation with five failing vectors
    for (int k = 0; k < 5; k++) wr(k, word(k, 1));
    run(5, 0); wait_done();
    chk("sat_cnt", 0, 64'(cnt0), 5);
    chk("sat_cnt", 1, 64'(cnt1), 3);
    chk("sat_cnt", 2, 64'(cnt2), 3);
    chk("sat_done_at", 1, 64'(done_at[1]), 15);
    chk("sat_done_at", 2, 64'(done_at[2]), 40);

    // Random vector sets, lengths and halt settings
    for (int it = 0; it < 25; it++) begin
      int n;
      n = $urandom_range(0, 12);
      for (int k = 0; k < n; k++) wr(k, 5'($urandom));
      run(n, 1'($urandom));
      wait_done();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
